fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage RV32I core; the block consumes the stall/flush controls produced by the hazard logic. It owns the PC register, next-PC selection, and the synchronous instruction-memory address. It also holds a fetched instruction across a stall, because that memory has one-cycle read latency. Its outputs feed the decode stage directly.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `CNT_W`, default 16: width of the saturating performance counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc_en` in 1: 1 = PC may advance sequentially.
- `if_id_en` in 1: 1 = IF/ID may load; 0 = hold.
- `if_id_flush` in 1: 1 = invalidate IF/ID (taken branch/jump).
- `if_mux_sel_ex` in 2: next-PC source. 0 = PC+4, 1 = `branch_target_ex`, 2 = `jalr_target_ex`, 3 = treated as 0.
- `branch_target_ex` in 32: branch/JAL target from EX.
- `jalr_target_ex` in 32: JALR target from EX.
- `imem_addr` out 32: instruction memory address; equals `pc_q`.
- `imem_rdata` in 32: memory data; the word for the address of cycle t is valid in cycle t+1.
- `if_id_pc` out 32: PC of the instruction in IF/ID.
- `if_id_pc_plus4` out 32: `if_id_pc` + 4.
- `if_id_instr` out 32: instruction in IF/ID; NOP 32'h0000_0013 when not valid.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `stall_cnt` out CNT_W: cycles with `if_id_en`=0 and `if_id_valid`=1.
- `flush_cnt` out CNT_W: cycles with `if_id_flush`=1.

## Operation
- Redirect: `if_mux_sel_ex` ∈ {1,2} loads `pc_q` with the selected target, bits [1:0] forced to 0. A redirect loads the PC even when `pc_en`=0.
- Sequential fetch: with no redirect and `pc_en`=1, `pc_q` <= `pc_q`+4 (mod 2^32, wraps to 0). With `pc_en`=0, `pc_q` holds.
- IF/ID priority: flush > hold > load.
  - Flush: `if_id_valid` <= 0 and `hold_valid` <= 0.
  - Load (`if_id_en`=1): `if_id_pc` <= `pc_q`, `if_id_valid` <= 1, `hold_valid` <= 0.
  - Hold (`if_id_en`=0): PC and valid bit unchanged.
- Hold buffer: on the first hold cycle with `hold_valid`=0, `hold_instr` <= `imem_rdata` and `hold_valid` <= 1. Later hold cycles do not overwrite it.
- Instruction output:
  - `if_id_instr` = NOP when `if_id_valid`=0.
  - Otherwise `hold_instr` when `hold_valid`=1.
  - Otherwise `imem_rdata`.
- Counters saturate at all-ones and never wrap.
- Reset (synchronous, `rst_n`=0 at an edge): `pc_q`=RESET_PC, `if_id_pc`=0, `if_id_valid`=0, `hold_valid`=0, `hold_instr`=NOP, both counters 0. Reset mid-stall or mid-redirect discards all state. `if_id_instr` reads NOP after reset.

## Timing
- Fetch latency: address at cycle t. The instruction appears on `if_id_instr` in cycle t+1, with `if_id_valid`=1 if IF/ID loaded at the end of cycle t.
- Redirect: in the cycle after the redirect edge, `imem_addr` = target. In the cycle after that, the target instruction is in IF/ID, so exactly one wrong-path slot is flushed.
- Stall: when `pc_en`=`if_id_en`=0 for N cycles, `if_id_pc`/`if_id_instr` stay constant for N+1 visible cycles. Fetch resumes with no lost or duplicated instruction.
- Flush and stall in the same cycle: the flush wins; the next cycle shows NOP with valid=0.
- `imem_rdata` is sampled only in the first stall cycle. There is no combinational path from `imem_rdata` to `imem_addr`.

## Structure
- `core_pkg` holds:
  - `if_sel_e` enum: IF_SEL_SEQ=0, IF_SEL_BRANCH=1, IF_SEL_JALR=2.
  - `NOP_INSTR` = 32'h0000_0013.
  - `XLEN` = 32.
- Sub-module `if_id_hold` contains the hold buffer and output mux: `hold_valid`/`hold_instr` regs plus the NOP/hold/rdata select.
- PC register, next-PC mux and counters stay in `fetch_stage`.

## Test plan
- Reset, then 4 free-running cycles → `imem_addr` 0,4,8,C. `if_id_valid` goes 0 then 1. `if_id_pc` 0,4,8 with matching `imem_rdata` words.
- Load-use stall: deassert `pc_en`/`if_id_en` for 1 cycle while IF/ID holds PC 8 (instr 0xAAAA_0003) and `imem_rdata` changes to 0xBBBB_0013 → `if_id_instr` = 0xAAAA_0003 for 2 cycles. Then PC C with no gap.
- Branch: `if_mux_sel_ex`=1, target 0x104, `if_id_flush`=1 → next cycle `imem_addr`=0x104 and `if_id_valid`=0, `if_id_instr`=NOP. The following cycle `if_id_pc`=0x104.
- JALR: sel=2, target 0x203 → `imem_addr`=0x200.
- Flush during stall, plus PC wrap: `if_id_en`=0 with `if_id_flush`=1 → valid=0 and `hold_valid` cleared, `flush_cnt`+1. Separately, `pc_q`=0xFFFF_FFFC advancing → `imem_addr`=0.
- Counter saturation with CNT_W=2: 5 stall cycles → `stall_cnt`=3. Reset mid-stall → `stall_cnt`=0 and `pc_q`=RESET_PC on the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I fetch path.
//   if_sel_e  - next-PC source select driven from EX
//   NOP_INSTR - canonical NOP (addi x0, x0, 0)
//   XLEN      - architectural register width
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_SEL_SEQ    = 2'd0,
    IF_SEL_BRANCH = 2'd1,
    IF_SEL_JALR   = 2'd2
  } if_sel_e;

endpackage

// File: rtl/fetch_stage_if_id_hold.sv
// if_id_hold: hold buffer and instruction select for the IF/ID register.
// The instruction memory has one cycle of read latency, so during a stall the
// word on imem_rdata moves on to the next address. The first stall cycle
// captures it here and later stall cycles present the captured copy.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   flush         - IF/ID invalidate (wins over hold and load)
//   load          - IF/ID load enable; 0 = hold
//   if_id_valid   - IF/ID valid bit from the stage register
//   imem_rdata    - instruction memory read data
//   if_id_instr   - instruction presented to decode (NOP when invalid)
module if_id_hold
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            if_id_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_instr
);

  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
    end else if (flush || load) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      // Only the first stall cycle sees the word belonging to IF/ID.
      hold_instr <= imem_rdata;
      hold_valid <= 1'b1;
    end
  end

  always_comb begin
    if_id_instr = NOP_INSTR;
    if (if_id_valid) begin
      if_id_instr = hold_valid ? hold_instr : imem_rdata;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch and IF/ID pipeline register for the
// five-stage RV32I core.
// Parameters:
//   RESET_PC - PC value after reset
//   CNT_W    - width of the saturating performance counters
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   pc_en             - allow sequential PC advance
//   if_id_en          - IF/ID load enable (0 = hold)
//   if_id_flush       - invalidate IF/ID
//   if_mux_sel_ex     - next-PC source (0 seq, 1 branch, 2 jalr, 3 seq)
//   branch_target_ex  - branch/JAL target
//   jalr_target_ex    - JALR target
//   imem_addr         - instruction memory address (the PC register)
//   imem_rdata        - instruction memory data, one cycle after the address
//   if_id_pc          - PC of the instruction in IF/ID
//   if_id_pc_plus4    - if_id_pc + 4
//   if_id_instr       - instruction in IF/ID, NOP when invalid
//   if_id_valid       - IF/ID holds a real instruction
//   stall_cnt         - cycles with IF/ID holding a valid instruction
//   flush_cnt         - cycles with a flush request
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_en,
  input  logic             if_id_en,
  input  logic             if_id_flush,
  input  logic [1:0]       if_mux_sel_ex,
  input  logic [31:0]      branch_target_ex,
  input  logic [31:0]      jalr_target_ex,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if_sel_e          pc_sel;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_next;

  assign pc_sel = if_sel_e'(if_mux_sel_ex);

  // Redirects ignore pc_en; encoding 3 falls through to sequential fetch.
  always_comb begin
    pc_next = pc_en ? pc_q + 32'd4 : pc_q;
    case (pc_sel)
      IF_SEL_BRANCH: pc_next = {branch_target_ex[31:2], 2'b00};
      IF_SEL_JALR:   pc_next = {jalr_target_ex[31:2], 2'b00};
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (if_id_flush) begin
      if_id_valid <= 1'b0;
    end else if (if_id_en) begin
      if_id_pc    <= pc_q;
      if_id_valid <= 1'b1;
    end
  end

  assign if_id_pc_plus4 = if_id_pc + 32'd4;

  if_id_hold u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (if_id_flush),
    .load        (if_id_en),
    .if_id_valid (if_id_valid),
    .imem_rdata  (imem_rdata),
    .if_id_instr (if_id_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!if_id_en && if_id_valid && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (if_id_flush && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-cycle-latency instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic [1:0]  if_mux_sel_ex;
  logic [31:0] branch_target_ex;
  logic [31:0] jalr_target_ex;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [1:0]  stall_cnt;
  logic [1:0]  flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .if_mux_sel_ex    (if_mux_sel_ex),
    .branch_target_ex (branch_target_ex),
    .jalr_target_ex   (jalr_target_ex),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  // Memory contents: two marked words, otherwise {addr[23:0], 8'h13}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'hAAAA_0003;
    if (a == 32'hC) return 32'hBBBB_0013;
    return {a[23:0], 8'h13};
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pe, input logic ie, input logic fl, input logic [1:0] sel);
    pc_en = pe;
    if_id_en = ie;
    if_id_flush = fl;
    if_mux_sel_ex = sel;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    branch_target_ex = 32'h0;
    jalr_target_ex = 32'h0;

    // Reset state
    step();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_stall", {30'b0, stall_cnt}, 32'h0);
    chk("rst_flush", {30'b0, flush_cnt}, 32'h0);
    $display("reset: addr=%h valid=%b instr=%h", imem_addr, if_id_valid, if_id_instr);

    // Free-running fetch
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("seq1_addr", imem_addr, 32'h4);
    chk("seq1_valid", {31'b0, if_id_valid}, 32'h1);
    chk("seq1_pc", if_id_pc, 32'h0);
    chk("seq1_instr", if_id_instr, 32'h0000_0013);
    $display("seq1: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);
    step();
    chk("seq2_addr", imem_addr, 32'h8);
    chk("seq2_pc", if_id_pc, 32'h4);
    chk("seq2_instr", if_id_instr, 32'h0000_0413);
    $display("seq2: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);
    step();
    chk("seq3_addr", imem_addr, 32'hC);
    chk("seq3_pc", if_id_pc, 32'h8);
    chk("seq3_instr", if_id_instr, 32'hAAAA_0003);
    $display("seq3: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);

    // Load-use stall for one cycle
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    step();
    chk("stall_addr", imem_addr, 32'hC);
    chk("stall_pc", if_id_pc, 32'h8);
    chk("stall_instr", if_id_instr, 32'hAAAA_0003);
    chk("stall_rdata", imem_rdata, 32'hBBBB_0013);
    chk("stall_cnt1", {30'b0, stall_cnt}, 32'h1);
    $display("stall: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("resume_addr", imem_addr, 32'h10);
    chk("resume_pc", if_id_pc, 32'hC);
    chk("resume_pc4", if_id_pc_plus4, 32'h10);
    chk("resume_instr", if_id_instr, 32'hBBBB_0013);
    $display("resume: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);

    // Taken branch to 0x104
    branch_target_ex = 32'h104;
    drive(1'b1, 1'b1, 1'b1, 2'd1);
    step();
    chk("br_addr", imem_addr, 32'h104);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);
    chk("br_instr", if_id_instr, NOP);
    chk("br_flushcnt", {30'b0, flush_cnt}, 32'h1);
    $display("branch: addr=%h valid=%b instr=%h", imem_addr, if_id_valid, if_id_instr);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("br2_addr", imem_addr, 32'h108);
    chk("br2_pc", if_id_pc, 32'h104);
    chk("br2_valid", {31'b0, if_id_valid}, 32'h1);
    chk("br2_instr", if_id_instr, 32'h0001_0413);
    $display("branch+1: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);

    // JALR to 0x203, low bits dropped
    jalr_target_ex = 32'h203;
    drive(1'b1, 1'b1, 1'b1, 2'd2);
    step();
    chk("jalr_addr", imem_addr, 32'h200);
    chk("jalr_flushcnt", {30'b0, flush_cnt}, 32'h2);
    $display("jalr: addr=%h valid=%b", imem_addr, if_id_valid);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("jalr2_addr", imem_addr, 32'h204);
    chk("jalr2_pc", if_id_pc, 32'h200);
    chk("jalr2_instr", if_id_instr, 32'h0002_0013);
    $display("jalr+1: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);

    // Stall one cycle (fills hold buffer), then flush while still stalled
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    step();
    chk("st2_pc", if_id_pc, 32'h200);
    chk("st2_instr", if_id_instr, 32'h0002_0013);
    chk("st2_cnt", {30'b0, stall_cnt}, 32'h2);
    $display("stall2: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);
    drive(1'b0, 1'b0, 1'b1, 2'd0);
    step();
    chk("fls_valid", {31'b0, if_id_valid}, 32'h0);
    chk("fls_instr", if_id_instr, NOP);
    chk("fls_flushcnt", {30'b0, flush_cnt}, 32'h3);
    chk("fls_addr", imem_addr, 32'h204);
    $display("flush-in-stall: valid=%b instr=%h flush_cnt=%0d", if_id_valid, if_id_instr, flush_cnt);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    // Stale hold contents would show 0x00020013 here.
    chk("fls2_pc", if_id_pc, 32'h204);
    chk("fls2_instr", if_id_instr, 32'h0002_0413);
    chk("fls2_addr", imem_addr, 32'h208);
    $display("after-flush: addr=%h pc=%h instr=%h", imem_addr, if_id_pc, if_id_instr);

    // PC wrap: redirect to 0xFFFFFFFE (aligns to FFFFFFFC), then advance
    branch_target_ex = 32'hFFFF_FFFE;
    drive(1'b1, 1'b1, 1'b1, 2'd1);
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("flush_sat", {30'b0, flush_cnt}, 32'h3);
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    step();
    chk("wrap_addr2", imem_addr, 32'h0);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    $display("wrap: addr=%h pc=%h pc4=%h", imem_addr, if_id_pc, if_id_pc_plus4);

    // Reset, one fetch, then saturate stall_cnt over 5 stall cycles
    rst_n = 1'b0;
    step();
    chk("rst2_stall", {30'b0, stall_cnt}, 32'h0);
    chk("rst2_flush", {30'b0, flush_cnt}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst2_valid", {31'b0, if_id_valid}, 32'h1);
    chk("rst2_addr", imem_addr, 32'h4);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("sat_%0d", i), {30'b0, stall_cnt}, (i >= 3) ? 32'h3 : 32'(i));
      $display("sat stall %0d: stall_cnt=%0d", i, stall_cnt);
    end

    // Reset in the middle of the stall
    rst_n = 1'b0;
    step();
    chk("rstm_stall", {30'b0, stall_cnt}, 32'h0);
    chk("rstm_addr", imem_addr, 32'h0);
    chk("rstm_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rstm_instr", if_id_instr, NOP);
    $display("reset-mid-stall: addr=%h stall_cnt=%0d valid=%b", imem_addr, stall_cnt, if_id_valid);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
